// File: rtl/shift_chain_sched.sv
// Two-requester scheduler driving an N-stage load/shift chain.
// It grants jobs round-robin, loads the job word, shifts it shamt times, then pulses done.
module shift_chain_sched #(
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          req0_valid,
  input  logic          req1_valid,
  input  logic [N-1:0]  req0_data,
  input  logic [N-1:0]  req1_data,
  input  logic [CW-1:0] req0_shamt,
  input  logic [CW-1:0] req1_shamt,
  output logic          req0_ready,
  output logic          req1_ready,
  input  logic          w_in,
  output logic          E,
  output logic          L,
  output logic [N-1:0]  Q,
  output logic          serial_out,
  output logic          busy,
  output logic          done,
  output logic          done_id,
  output logic [1:0]    state_dbg
);

  // Handshake: in IDLE a requester's job is taken in any cycle where its
  // valid and its ready are both high; ready is never high outside IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q;
  logic [N-1:0]  r_q;
  logic [CW-1:0] shamt_q;
  logic [CW-1:0] cnt_q;
  logic          owner_q;
  logic          last_q;
  logic          e_q;
  logic          l_q;
  logic          done_q;
  logic          busy_q;
  logic [N-1:0]  q_q;
  logic [N-1:0]  q_d;
  logic [N-1:0]  w_vec;

  logic gnt0_d;
  logic gnt1_d;
  logic accept_d;

  // last_q names the requester granted most recently; the other one wins a tie.
  always_comb begin
    gnt0_d   = req0_valid & (~req1_valid | last_q);
    gnt1_d   = req1_valid & (~req0_valid | ~last_q);
    accept_d = (state_q == IDLE) & (gnt0_d | gnt1_d);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      r_q     <= '0;
      shamt_q <= '0;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      e_q     <= 1'b0;
      l_q     <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            state_q <= LOAD;
            r_q     <= gnt1_d ? req1_data : req0_data;
            shamt_q <= gnt1_d ? req1_shamt : req0_shamt;
            owner_q <= gnt1_d;
            last_q  <= gnt1_d;
            l_q     <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          l_q   <= 1'b0;
          cnt_q <= shamt_q;
          if (shamt_q == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= SHIFT;
            e_q     <= 1'b1;
          end
        end
        SHIFT: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= DONE;
            e_q     <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Stage N-1 takes w_in, every other stage takes its upper neighbour (N >= 2).
  always_comb begin
    w_vec = {w_in, q_q[N-1:1]};
    if (l_q)
      q_d = r_q;
    else if (e_q)
      q_d = w_vec;
    else
      q_d = q_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn)
      q_q <= '0;
    else
      q_q <= q_d;
  end

  // Gating with resetn keeps the chain controls and done quiet while reset is held.
  assign req0_ready = resetn & (state_q == IDLE) & gnt0_d;
  assign req1_ready = resetn & (state_q == IDLE) & gnt1_d;
  assign E          = e_q & resetn;
  assign L          = l_q & resetn;
  assign done       = done_q & resetn;
  assign done_id    = owner_q;
  assign busy       = busy_q;
  assign Q          = q_q;
  assign serial_out = q_q[0];
  assign state_dbg  = state_q;

endmodule

// File: doc/shift_chain_sched.md
SHIFT_CHAIN_SCHED -- requirements
Module: shift_chain_sched

Interface
REQ-001 SHALL have parameter N, default 4: number of chain stages.
REQ-002 SHALL have parameter CW, default 3: shift-count width.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have ports req0_valid, input, 1 and req1_valid, input, 1: requester job present.
REQ-006 SHALL have ports req0_data, input, N and req1_data, input, N: parallel load word.
REQ-007 SHALL have ports req0_shamt, input, CW and req1_shamt, input, CW: number of shifts after the load.
REQ-008 SHALL have ports req0_ready, output, 1 and req1_ready, output, 1: job accepted this cycle.
REQ-009 SHALL have port w_in, input, 1: serial input to stage N-1.
REQ-010 SHALL have port E, output, 1: chain shift enable.
REQ-011 SHALL have port L, output, 1: chain load.
REQ-012 SHALL have port Q, output, N: chain contents.
REQ-013 SHALL have port serial_out, output, 1: equal to Q[0].
REQ-014 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-015 SHALL have ports done, output, 1 and done_id, output, 1: job-complete pulse and the requester that owned the job.

Function
REQ-016 SHALL implement each stage i on every clk edge as follows:
- Q[i] takes R[i] when L=1;
- otherwise Q[i] takes w_i when E=1;
- otherwise Q[i] holds.
- w_i is Q[i+1] for i<N-1, and w_in for i=N-1; R is the captured job data.
REQ-017 SHALL use a four-state FSM: IDLE, LOAD, SHIFT, DONE.
REQ-018 SHALL, in IDLE with at least one valid, assert ready combinationally for exactly one granted requester, capture its data and shamt, and move to LOAD.
REQ-019 SHALL arbitrate round-robin:
- a single valid requester is granted;
- when both are valid, the requester not granted last is granted;
- the last-grant pointer updates only on acceptance.
REQ-020 SHALL drive L=1 and E=0 in LOAD.
- After LOAD: go to DONE if shamt=0, else go to SHIFT with counter=shamt.
REQ-021 SHALL drive E=1 and L=0 in SHIFT, decrementing the counter each cycle.
- Leave for DONE after the cycle in which the counter equals 1.
REQ-022 SHALL drive E=0 and L=0 in DONE, assert done=1 for exactly one cycle with done_id set to the job owner, then return to IDLE.
REQ-023 SHALL never assert E and L in the same cycle, and SHALL keep E=L=0 in IDLE and DONE, so Q holds.
REQ-024 SHALL deassert both ready outputs outside IDLE; valids arriving while busy stay pending and are arbitrated on return to IDLE.
REQ-025 SHALL give fixed latency: a job accepted in cycle t has done high in cycle t+2+shamt.
- The next acceptance happens no earlier than cycle t+3+shamt.
REQ-026 SHALL treat shamt as unsigned; a maximum shamt of 2^CW-1 gives exactly 2^CW-1 SHIFT cycles with no wrap.
REQ-027 SHALL sample w_in in each SHIFT cycle only.
- Shamt greater than N flushes the loaded word fully out, and the chain then holds the last N w_in samples.

Reset
REQ-028 SHALL, on a clk edge with resetn=0, set state=IDLE, Q=0, counter=0, and last-grant pointer=1, so req0 wins the first contention.
- During that reset cycle: done=0, ready=0, E=0, L=0.
REQ-029 SHALL abort any job in progress on reset without producing a done pulse; the aborted job is not retried.

Verification
REQ-030 SHALL cover load-only: req0 with data=4'b1011, shamt=0 -> ready0 pulses 1 cycle, L high 1 cycle, Q=1011, done=1 with done_id=0 two cycles after accept.
REQ-031 SHALL cover load then shift: req1 with data=4'b1001, shamt=2, w_in=1 -> E high 2 cycles, Q=1110, serial_out sequence 1,0,0 after the load, done_id=1 at t+4.
REQ-032 SHALL cover contention: both valid from reset -> req0 granted first, req1 granted at the next IDLE, req0 granted at the following IDLE, strictly alternating.
REQ-033 SHALL cover overflow shift: shamt=7, w_in=0 -> 7 consecutive E cycles, Q=0000, done at t+9.
REQ-034 SHALL cover reset mid-job: resetn=0 during the 2nd SHIFT cycle -> next cycle Q=0, busy=0, no done pulse, req0 wins the next contention.
REQ-035 SHALL cover valid during busy: req1 asserted while a req0 job runs -> req1_ready stays 0 until IDLE, and req1 is accepted in the cycle after done.
